slot_rom_responder: RTL and testbench

SLOT_ROM_RESPONDER -- requirements
Module: slot_rom_responder

---
 rtl/slot_rom_responder_if.sv | 25 ++
 rtl/slot_rom_responder.sv | 84 ++++++++
 tb/tb_slot_rom_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/slot_rom_responder_if.sv
// slot_rom_responder_if: CPU slot bus plus ROM read port shared by the responder and its host
//   CPU side : sltsl_n, addr, d_in, rd_n, wr_n (to responder); d_out, d_oe, wait_n (from responder)
//   ROM side : mem_addr, mem_rd (from responder); mem_ack, mem_data (to responder)
interface slot_rom_if #(parameter int MEM_AW = 21);
  logic              sltsl_n;
  logic [15:0]       addr;
  logic [7:0]        d_in;
  logic              rd_n;
  logic              wr_n;
  logic [7:0]        d_out;
  logic              d_oe;
  logic              wait_n;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [7:0]        mem_data;
  modport slave (
    input  sltsl_n, addr, d_in, rd_n, wr_n, mem_ack, mem_data,
    output d_out, d_oe, wait_n, mem_addr, mem_rd
  );
  modport master (
    output sltsl_n, addr, d_in, rd_n, wr_n, mem_ack, mem_data,
    input  d_out, d_oe, wait_n, mem_addr, mem_rd
  );
endinterface

// File: rtl/slot_rom_responder.sv
// slot_rom_responder: ASCII8 bank-switched cartridge ROM responder with wait-state ROM fetch
//   clk   : rising-edge system clock
//   reset : asynchronous, active-high
//   bus   : slot_rom_if.slave -- CPU strobes/data in, read data/d_oe/wait_n out, ROM read port
module slot_rom_responder #(
  parameter int         MEM_AW    = 21,
  parameter logic [7:0] BANK_MASK = 8'hFF
) (
  input logic      clk,
  input logic      reset,
  slot_rom_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRIVE} state_t;
  state_t            state_q, state_d;
  logic [7:0]        bank_q [4];
  logic [7:0]        d_out_q, d_out_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              wr_n_q;
  logic              rd_act, in_rom, wr_det;
  logic [1:0]        pg;
  logic [20:0]       full;
  logic [7:0]        d_out;
  logic              d_oe, wait_n, mem_rd;
  // reset gating keeps wait_n high and d_oe low while reset is held, even with a strobe active
  assign rd_act = !reset && !bus.sltsl_n && !bus.rd_n;
  assign in_rom = bus.addr[15:14] == 2'b01 || bus.addr[15:14] == 2'b10;
  assign wr_det = !bus.sltsl_n && !bus.wr_n && wr_n_q;
  // addr[15:13]-2 over pages 2..5 reduces to flipping bit 14
  assign pg     = bus.addr[14:13] ^ 2'b10;
  assign full   = {bank_q[pg] & BANK_MASK, bus.addr[12:0]};
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    d_out_d    = d_out_q;
    d_out      = d_out_q;
    d_oe       = 1'b0;
    wait_n     = 1'b1;
    mem_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_act && in_rom) begin
          state_d    = REQ;
          mem_addr_d = MEM_AW'(full);
          wait_n     = 1'b0;
        end else if (rd_act) begin
          d_out = 8'hFF;
          d_oe  = 1'b1;
        end
      end
      REQ, WAIT: begin
        mem_rd  = state_q == REQ;
        wait_n  = bus.mem_ack;
        d_out_d = bus.mem_ack ? bus.mem_data : d_out_q;
        state_d = bus.mem_ack ? DRIVE : WAIT;
      end
      DRIVE: begin
        d_oe    = 1'b1;
        state_d = (bus.rd_n || bus.sltsl_n) ? IDLE : DRIVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bank_q     <= '{default: 8'h00};
      d_out_q    <= 8'hFF;
      mem_addr_q <= '0;
      wr_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      d_out_q    <= d_out_d;
      mem_addr_q <= mem_addr_d;
      wr_n_q     <= bus.wr_n;
      // bank writes are independent of the read FSM; an in-flight read keeps its latched mem_addr
      if (wr_det && bus.addr[15:13] == 3'b011) bank_q[bus.addr[12:11]] <= bus.d_in;
    end
  end
  assign bus.d_out    = d_out;
  assign bus.d_oe     = d_oe;
  assign bus.wait_n   = wait_n;
  assign bus.mem_rd   = mem_rd;
  assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_slot_rom_responder.sv
// tb_slot_rom_responder: directed self-checking bench for slot_rom_responder (unmasked and BANK_MASK=0F instances)
module tb_slot_rom_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int wl = 0;
  int mr = 0;
  int w0, m0;
  slot_rom_if #(.MEM_AW(21)) b1 ();
  slot_rom_if #(.MEM_AW(21)) b2 ();
  slot_rom_responder #(.MEM_AW(21), .BANK_MASK(8'hFF)) dut (.clk(clk), .reset(reset), .bus(b1.slave));
  slot_rom_responder #(.MEM_AW(21), .BANK_MASK(8'h0F)) dut_m (.clk(clk), .reset(reset), .bus(b2.slave));
  assign b2.sltsl_n  = b1.sltsl_n;
  assign b2.addr     = b1.addr;
  assign b2.d_in     = b1.d_in;
  assign b2.rd_n     = b1.rd_n;
  assign b2.wr_n     = b1.wr_n;
  assign b2.mem_ack  = b1.mem_ack;
  assign b2.mem_data = b1.mem_data;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!b1.wait_n) wl <= wl + 1;
    if (b1.mem_rd) mr <= mr + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic rel;
    b1.rd_n = 1'b1;
    b1.sltsl_n = 1'b1;
    b1.wr_n = 1'b1;
    cyc;
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    b1.sltsl_n = 1'b0;
    b1.wr_n = 1'b0;
    b1.addr = a;
    b1.d_in = d;
    cyc;
    b1.wr_n = 1'b1;
    b1.sltsl_n = 1'b1;
    cyc;
  endtask
  task automatic rd_go(input logic [15:0] a);
    b1.sltsl_n = 1'b0;
    b1.rd_n = 1'b0;
    b1.addr = a;
    cyc;
  endtask
  task automatic ack(input logic [7:0] d);
    b1.mem_ack = 1'b1;
    b1.mem_data = d;
    cyc;
    b1.mem_ack = 1'b0;
  endtask
  initial begin
    b1.sltsl_n = 1'b1; b1.rd_n = 1'b1; b1.wr_n = 1'b1;
    b1.addr = '0; b1.d_in = '0; b1.mem_ack = 1'b0; b1.mem_data = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_dout", b1.d_out, 8'hFF);
    chk("rst_doe", b1.d_oe, 0);
    chk("rst_wait", b1.wait_n, 1);
    chk("rst_memrd", b1.mem_rd, 0);
    chk("rst_maddr", b1.mem_addr, 0);
    cyc; cyc;
    reset = 1'b0;
    cyc;
    w0 = wl; m0 = mr;
    b1.sltsl_n = 1'b0; b1.rd_n = 1'b0; b1.addr = 16'h4000;
    #1;
    chk("r0_start_wait", b1.wait_n, 0);
    chk("r0_start_memrd", b1.mem_rd, 0);
    cyc;
    chk("r0_memrd", b1.mem_rd, 1);
    chk("r0_maddr", b1.mem_addr, 21'h000000);
    cyc;
    chk("r0_memrd_once", b1.mem_rd, 0);
    cyc; cyc;
    b1.mem_ack = 1'b1; b1.mem_data = 8'hA5;
    #1;
    chk("r0_ack_wait", b1.wait_n, 1);
    cyc;
    b1.mem_ack = 1'b0;
    chk("r0_dout", b1.d_out, 8'hA5);
    chk("r0_doe", b1.d_oe, 1);
    rel;
    chk("r0_rel_doe", b1.d_oe, 0);
    chk("r0_wait_cycles", wl - w0, 4);
    chk("r0_memrd_count", mr - m0, 1);
    wr(16'h6800, 8'h05);
    rd_go(16'h6123);
    chk("r1_maddr", b1.mem_addr, 21'h00A123);
    chk("r1_maddr_m", b2.mem_addr, 21'h00A123);
    chk("r1_memrd", b1.mem_rd, 1);
    b1.mem_ack = 1'b1; b1.mem_data = 8'h3C;
    #1;
    chk("r1_reqack_wait", b1.wait_n, 1);
    cyc;
    b1.mem_ack = 1'b0;
    chk("r1_dout", b1.d_out, 8'h3C);
    chk("r1_doe", b1.d_oe, 1);
    rel;
    chk("r1_rel_doe", b1.d_oe, 0);
    wr(16'h7000, 8'h37);
    rd_go(16'h8001);
    chk("r2_maddr", b1.mem_addr, 21'h06E001);
    chk("r2_maddr_m", b2.mem_addr, 21'h00E001);
    cyc;
    b1.wr_n = 1'b0; b1.addr = 16'h7000; b1.d_in = 8'h11;
    cyc;
    b1.wr_n = 1'b1; b1.addr = 16'h8001;
    chk("r2_held_maddr", b1.mem_addr, 21'h06E001);
    chk("r2_wait_busy", b1.wait_n, 0);
    ack(8'h5A);
    chk("r2_dout", b1.d_out, 8'h5A);
    rel;
    rd_go(16'h8001);
    chk("r3_maddr", b1.mem_addr, 21'h022001);
    chk("r3_maddr_m", b2.mem_addr, 21'h002001);
    ack(8'h00);
    rel;
    m0 = mr;
    b1.sltsl_n = 1'b0; b1.rd_n = 1'b0; b1.addr = 16'h2000;
    #1;
    chk("oor_dout", b1.d_out, 8'hFF);
    chk("oor_doe", b1.d_oe, 1);
    chk("oor_wait", b1.wait_n, 1);
    cyc; cyc;
    chk("oor_dout_held", b1.d_out, 8'hFF);
    chk("oor_doe_held", b1.d_oe, 1);
    chk("oor_wait_held", b1.wait_n, 1);
    chk("oor_no_memrd", mr - m0, 0);
    rel;
    chk("oor_rel_doe", b1.d_oe, 0);
    b1.sltsl_n = 1'b0; b1.wr_n = 1'b0; b1.addr = 16'h7800; b1.d_in = 8'h12;
    cyc;
    b1.d_in = 8'h34;
    repeat (4) cyc;
    b1.wr_n = 1'b1; b1.sltsl_n = 1'b1;
    cyc;
    wr(16'h5000, 8'hFF);
    rd_go(16'hA000);
    chk("r4_maddr", b1.mem_addr, 21'h024000);
    chk("r4_maddr_m", b2.mem_addr, 21'h004000);
    ack(8'h66);
    chk("r4_dout", b1.d_out, 8'h66);
    rel;
    rd_go(16'h6000);
    chk("r5_maddr", b1.mem_addr, 21'h00A000);
    cyc;
    chk("r5_wait_busy", b1.wait_n, 0);
    reset = 1'b1; b1.rd_n = 1'b1; b1.sltsl_n = 1'b1;
    #1;
    chk("r5_rst_wait", b1.wait_n, 1);
    chk("r5_rst_maddr", b1.mem_addr, 0);
    chk("r5_rst_dout", b1.d_out, 8'hFF);
    cyc;
    reset = 1'b0;
    b1.mem_ack = 1'b1; b1.mem_data = 8'h77;
    #1;
    chk("r5_lateack_doe", b1.d_oe, 0);
    chk("r5_lateack_wait", b1.wait_n, 1);
    cyc;
    b1.mem_ack = 1'b0;
    chk("r5_idle_doe", b1.d_oe, 0);
    chk("r5_idle_dout", b1.d_out, 8'hFF);
    chk("r5_idle_memrd", b1.mem_rd, 0);
    rd_go(16'h6000);
    chk("r6_memrd", b1.mem_rd, 1);
    chk("r6_maddr", b1.mem_addr, 21'h000000);
    ack(8'h81);
    chk("r6_dout", b1.d_out, 8'h81);
    chk("r6_doe", b1.d_oe, 1);
    rel;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
